// File: rtl/ahb_slave_if.sv
// AHB slave front end: address decode/qualify, 1- and 2-cycle pipelines, read-data pass-through, and a two-cycle ERROR response.
// valid/tempselx/hrdata are same-cycle; ERROR starts the cycle after the bad address phase; there is no backpressure beyond err_hreadyout.
module ahb_slave_if #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 hwrite,
  input  logic                 hreadyin,
  input  logic [1:0]           htrans,
  input  logic [31:0]          haddr,
  input  logic [31:0]          hwdata,
  input  logic [31:0]          prdata,
  output logic                 valid,
  output logic [2:0]           tempselx,
  output logic [31:0]          haddr1,
  output logic [31:0]          haddr2,
  output logic [31:0]          hwdata1,
  output logic [31:0]          hwdata2,
  output logic                 hwrite_reg,
  output logic                 hwrite_reg1,
  output logic [31:0]          hrdata,
  output logic [1:0]           hresp,
  output logic                 err_hreadyout,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

  state_t state, state_nxt;
  logic   active;
  logic   in_range;
  logic   err_inc;

  // Only NONSEQ/SEQ with the master ready count as transfers.
  assign active   = hreadyin & ((htrans == 2'b10) | (htrans == 2'b11));
  assign in_range = |tempselx;
  assign valid    = active & in_range;
  assign hrdata   = prdata;

  always_comb begin
    tempselx = 3'b000;
    if (haddr >= 32'h8000_0000 && haddr <= 32'h83FF_FFFF)
      tempselx = 3'b001;
    else if (haddr >= 32'h8400_0000 && haddr <= 32'h87FF_FFFF)
      tempselx = 3'b010;
    else if (haddr >= 32'h8800_0000 && haddr <= 32'h8BFF_FFFF)
      tempselx = 3'b100;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr1      <= '0;
      haddr2      <= '0;
      hwdata1     <= '0;
      hwdata2     <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
    end else begin
      haddr1      <= haddr;
      haddr2      <= haddr1;
      hwdata1     <= hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg  <= hwrite;
      hwrite_reg1 <= hwrite_reg;
    end
  end

  // ERR1 ignores inputs so the first ERROR cycle always completes.
  always_comb begin
    state_nxt = state;
    err_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (active && !in_range) begin
          state_nxt = S_ERR1;
          err_inc   = 1'b1;
        end
      end
      S_ERR1: state_nxt = S_ERR2;
      S_ERR2: begin
        if (active && !in_range) begin
          state_nxt = S_ERR1;
          err_inc   = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= S_IDLE;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      if (err_inc && err_count != {ERR_CNT_W{1'b1}})
        err_count <= err_count + 1'b1;
    end
  end

  assign hresp         = (state == S_IDLE) ? 2'b00 : 2'b01;
  assign err_hreadyout = (state != S_ERR1);

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB slave-side front end of the AHB-to-APB bridge; sits directly downstream of the AHB master.
- Qualifies each AHB transfer and decodes the address into one of three APB peripheral selects.
- Pipelines address, write data and direction for the bridge FSM, and returns read data.
- Generates a two-cycle AHB ERROR response for out-of-map transfers and counts those errors.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- hclk  in  1  bridge clock; all state updates on its rising edge.
- hreset  in  1  synchronous, active-high reset.
- hwrite  in  1  transfer direction from the master; 1 = write.
- hreadyin  in  1  master ready/qualify.
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- haddr  in  32  address-phase address.
- hwdata  in  32  data-phase write data.
- prdata  in  32  read data from the selected APB peripheral.
- valid  out  1  qualified in-map transfer; combinational.
- tempselx  out  3  one-hot peripheral select; combinational.
- haddr1, haddr2  out  32 each  address delayed 1 and 2 cycles.
- hwdata1, hwdata2  out  32 each  write data delayed 1 and 2 cycles.
- hwrite_reg, hwrite_reg1  out  1 each  hwrite delayed 1 and 2 cycles.
- hrdata  out  32  read data to the master.
- hresp  out  2  00 OKAY, 01 ERROR.
- err_hreadyout  out  1  low only during the first ERROR cycle; the bridge ANDs it into hreadyout.
- err_count  out  ERR_CNT_W  saturating count of rejected transfers.

Behaviour:
- Address map (inclusive ranges), in_range = any hit:
  - 0x8000_0000–0x83FF_FFFF -> tempselx 001
  - 0x8400_0000–0x87FF_FFFF -> tempselx 010
  - 0x8800_0000–0x8BFF_FFFF -> tempselx 100
  - any other address -> tempselx 000
- active = hreadyin & htrans[1] (NONSEQ or SEQ). IDLE and BUSY are never active.
- valid = active & in_range. Combinational, no latency.
- Pipeline: every clock, haddr1<=haddr, haddr2<=haddr1; hwdata1<=hwdata, hwdata2<=hwdata1; hwrite_reg<=hwrite, hwrite_reg1<=hwrite_reg. Updates are unconditional, not gated by hreadyin; one and two cycles of latency respectively.
- hrdata = prdata, combinational pass-through.
- Error FSM states: IDLE, ERR1, ERR2.
  - IDLE: hresp=00, err_hreadyout=1. If active & !in_range, go to ERR1 and increment err_count.
  - ERR1: hresp=01, err_hreadyout=0. Always go to ERR2.
  - ERR2: hresp=01, err_hreadyout=1.
    - If active & !in_range again, go to ERR1 and increment err_count.
    - Otherwise go to IDLE.
  - Inputs are ignored in ERR1; a transfer presented there is not counted or decoded for error.
- Outputs are Moore-decoded from state. ERROR response therefore starts the cycle after the offending address phase.
- err_count saturates at all-ones; no wrap.
- Reset (synchronous, hreset=1 at a rising edge), overriding everything including a mid-ERROR sequence:
  - state=IDLE, hresp=00, err_hreadyout=1, err_count=0.
  - All pipeline registers = 0, hwrite_reg = hwrite_reg1 = 0.
  - valid/tempselx stay combinational during reset.
- Simultaneous events: an in-map transfer arriving while in ERR2 asserts valid and returns the FSM to IDLE; it is not counted.

Test Plan:
- Reset: hreset=1 for 2 cycles with random inputs -> all registered outputs 0, hresp=00, err_hreadyout=1, err_count=0.
- Single write: haddr=0x8000_0011, hwrite=1, htrans=10, hreadyin=1; next cycle hwdata=0x8000_0CCC -> valid=1 and tempselx=001 that cycle.
  - Next edge: haddr1=0x8000_0011, hwrite_reg=1.
  - Two edges after the data phase: hwdata2=0x8000_0CCC.
- Single read plus decode sweep: haddr=0x8000_FFFF / 0x8400_0000 / 0x8BFF_FFFF, hwrite=0, htrans=10.
  - Expect tempselx 001 / 010 / 100 and valid=1.
  - prdata=0xA5A5_1234 appears on hrdata the same cycle.
- Non-qualifying transfers: htrans=00 or 01 at 0x8000_0000, and htrans=10 with hreadyin=0 -> valid=0, FSM stays IDLE.
- Out of map: haddr=0x9000_0000, htrans=10, hreadyin=1 -> next cycle hresp=01, err_hreadyout=0; following cycle hresp=01, err_hreadyout=1; then hresp=00; err_count=1.
  - Repeat the sequence while in ERR2 -> returns to ERR1; err_count=2.
- Saturation and reset mid-error: ERR_CNT_W=2, inject 5 bad transfers -> err_count holds at 3.
  - Assert hreset during ERR1 -> next cycle IDLE, hresp=00, err_count=0.
